uart_dec: RTL
=============

Name: uart_dec

Overview:
- Receive-side counterpart of the UART ASCII encoder.
- Consumes the byte stream from the UART receiver one byte at a time and parses terminated ASCII command lines into strobes toward the core:
  - hex-data lines become a 32-bit value;
  - an "R" line becomes a state-read request;
  - malformed lines are flagged.
- Sits between the UART RX byte deserialiser and the command/register logic.

Parameters:
- MAX_DIGITS, 8, maximum hex digits per data line (8 digits × 4 bits = 32-bit DATA_OUT).
- TIMEOUT_CYC, 1000000, idle cycles allowed between bytes of a partial line before it is abandoned; 0 disables the timeout.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- RX_DATA  in  8  received byte
- RX_VALID  in  1  one-cycle strobe, RX_DATA valid; no backpressure, at most one byte per cycle
- DATA_OUT  out  32  last parsed value, right-justified, held until the next successful data line
- DATA_VALID  out  1  one-cycle pulse, DATA_OUT updated this cycle
- STATE_R_REQ  out  1  one-cycle pulse, "R" line received
- FAIL_OUT  out  1  one-cycle pulse, line rejected (bad char, overflow, timeout)
- BUSY  out  1  high while a line is partially received (state not IDLE)

Behaviour:
- Reset: all outputs 0, state IDLE, accumulator 0, digit count 0, timeout counter 0.
- Terminator (TERM) is CR 8'h0D or LF 8'h0A. Hex digits are 0x30-0x39 → 0-9 and 0x41-0x46 → A-F.
- States:
  - IDLE:
    - TERM → stay (empty lines, including the LF of a CRLF pair, are ignored silently).
    - Hex digit → HEX, with acc = nibble, count = 1.
    - 'R' 8'h52 → CMD_R.
    - Any other byte → ERR.
  - HEX:
    - Hex digit with count < MAX_DIGITS → acc = {acc[27:0], nibble}, count++.
    - Hex digit with count = MAX_DIGITS → ERR (overflow).
    - TERM → DONE_D.
    - Other → ERR.
  - CMD_R:
    - TERM → DONE_R.
    - Any other byte → ERR.
  - ERR: discard bytes until TERM, then DONE_F.
  - DONE_D / DONE_R / DONE_F: single-cycle states, then IDLE.
- Outputs are registered.
  - DONE_D: DATA_OUT = acc and DATA_VALID = 1.
  - DONE_R: STATE_R_REQ = 1.
  - DONE_F: FAIL_OUT = 1.
- Latency: pulse asserts 2 cycles after the TERM byte's RX_VALID cycle (TERM → DONE_x → registered pulse).
- Pulses are mutually exclusive and never longer than one cycle.
- A byte arriving while in a DONE_x state is processed as if in IDLE in that same cycle. No byte is lost.
- Fewer than 8 digits are zero-extended: "1F" → 32'h0000_001F.
- Timeout:
  - The counter runs in HEX, CMD_R and ERR, and clears on every RX_VALID.
  - When it reaches TIMEOUT_CYC: FAIL_OUT pulse, state → IDLE, acc and count cleared.
  - If RX_VALID arrives in the same cycle the timeout fires, the timeout wins and the byte is dropped.
- RST_N low at any time, including mid-line: immediate return to reset values; the partial line is lost and no pulse is produced.

Optional Feature:
- UART_DEC_LOWERCASE_EN defined: 0x61-0x66 ('a'-'f') are also accepted as hex digits 10-15, and 'r' 8'h72 is accepted as the read command.
- Not defined: lowercase characters are "other" bytes and lead to ERR / FAIL_OUT.

Decomposition:
- Package uart_pkg holds:
  - ASCII constants: CHR_CR 8'h0D, CHR_LF 8'h0A, CHR_R 8'h52, CHR_PROMPT 8'h3E;
  - decoder state encoding localparams (IDLE, HEX, CMD_R, ERR, DONE_D, DONE_R, DONE_F);
  - the nibble-to-ASCII table shared with the encoder.
- One combinational sub-module, ascii_hex_nib: byte in → nibble[3:0] + is_hex flag. The UART_DEC_LOWERCASE_EN macro is honoured inside it.

Test Plan:
- Bytes "12AB34CD",0x0A → DATA_OUT = 32'h12AB_34CD, one DATA_VALID pulse 2 cycles after the LF; no FAIL_OUT.
- Bytes "7",0x0D,0x0A → DATA_OUT = 32'h0000_0007, single DATA_VALID; the trailing LF is ignored (no second pulse, no FAIL_OUT).
- Bytes "R",0x0D → STATE_R_REQ single pulse, DATA_OUT unchanged; then "RX",0x0D → FAIL_OUT pulse, STATE_R_REQ stays 0.
- Bytes "123456789",0x0A (9 digits) → FAIL_OUT pulse, DATA_OUT keeps its previous value; a following "5",0x0A → DATA_VALID with 32'h0000_0005.
- TIMEOUT_CYC=16: "AB", then 16 idle cycles → FAIL_OUT pulse, BUSY low. Assert RST_N low after "CD" → outputs 0, and the next "1",0x0A yields 32'h1.
- With UART_DEC_LOWERCASE_EN: "dead",0x0A → 32'h0000_DEAD. Without it: the same input → FAIL_OUT.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared ASCII constants, decoder state encoding and the
// nibble-to-ASCII helper used by both the UART encoder and decoder.
package uart_pkg;

    localparam logic [7:0] CHR_CR     = 8'h0D;
    localparam logic [7:0] CHR_LF     = 8'h0A;
    localparam logic [7:0] CHR_R      = 8'h52;
    localparam logic [7:0] CHR_R_LC   = 8'h72;
    localparam logic [7:0] CHR_PROMPT = 8'h3E;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEX    = 3'd1,
        ST_CMD_R  = 3'd2,
        ST_ERR    = 3'd3,
        ST_DONE_D = 3'd4,
        ST_DONE_R = 3'd5,
        ST_DONE_F = 3'd6
    } dec_state_t;

    // Uppercase hex character for a nibble; the encoder uses this table.
    function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'h0, nib};
        if (nib < 4'd10) begin
            return 8'h30 + wide;
        end
        return 8'h37 + wide;
    endfunction

    // Either line terminator ends a command line.
    function automatic logic is_term(input logic [7:0] chr);
        return (chr == CHR_CR) || (chr == CHR_LF);
    endfunction

endpackage

// File: rtl/ascii_hex_nib.sv
// ascii_hex_nib: combinational ASCII hex character to nibble decoder.
// Define UART_DEC_LOWERCASE_EN to also accept 'a'-'f'.
module ascii_hex_nib (
    input  logic [7:0] char_in,
    output logic [3:0] nibble,
    output logic       is_hex
);

    // Map '0'-'9' and 'A'-'F' (and optionally 'a'-'f') onto 0-15.
    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            nibble = char_in[3:0];
            is_hex = 1'b1;
        end else if (char_in >= 8'h41 && char_in <= 8'h46) begin
            nibble = char_in[3:0] + 4'd9;
            is_hex = 1'b1;
        end
`ifdef UART_DEC_LOWERCASE_EN
        else if (char_in >= 8'h61 && char_in <= 8'h66) begin
            nibble = char_in[3:0] + 4'd9;
            is_hex = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/uart_dec.sv
// uart_dec: parses terminated ASCII lines from the UART receiver into
// data, state-read and failure strobes for the command logic.
// Define UART_DEC_LOWERCASE_EN to accept lowercase hex digits and 'r'.
module uart_dec
    import uart_pkg::*;
#(
    parameter int unsigned MAX_DIGITS  = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic [31:0] DATA_OUT,
    output logic        DATA_VALID,
    output logic        STATE_R_REQ,
    output logic        FAIL_OUT,
    output logic        BUSY
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int unsigned TO_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DIGITS);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC);

    dec_state_t       state;
    dec_state_t       cur_state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       nib;
    logic             is_hex;
    logic             rx_term;
    logic             rx_rcmd;
    logic             in_line;
    logic             is_done;
    logic             timeout_hit;

    ascii_hex_nib u_nib (
        .char_in (RX_DATA),
        .nibble  (nib),
        .is_hex  (is_hex)
    );

    // Classify the incoming byte and derive state-level flags; a DONE state
    // behaves like IDLE for the byte arriving in it so nothing is dropped.
    always_comb begin
        rx_term = is_term(RX_DATA);
`ifdef UART_DEC_LOWERCASE_EN
        rx_rcmd = (RX_DATA == CHR_R) || (RX_DATA == CHR_R_LC);
`else
        rx_rcmd = (RX_DATA == CHR_R);
`endif
        in_line = (state == ST_HEX) || (state == ST_CMD_R) || (state == ST_ERR);
        is_done = (state == ST_DONE_D) || (state == ST_DONE_R) || (state == ST_DONE_F);
        cur_state   = is_done ? ST_IDLE : state;
        timeout_hit = (TIMEOUT_CYC != 0) && in_line && (to_cnt == TO_LIMIT);
    end

    assign BUSY = (state != ST_IDLE);

    // Line parser FSM with registered strobes; a timeout takes priority
    // over any byte arriving in the same cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            acc         <= '0;
            cnt         <= '0;
            to_cnt      <= '0;
            DATA_OUT    <= '0;
            DATA_VALID  <= 1'b0;
            STATE_R_REQ <= 1'b0;
            FAIL_OUT    <= 1'b0;
        end else begin
            DATA_VALID  <= 1'b0;
            STATE_R_REQ <= 1'b0;
            FAIL_OUT    <= 1'b0;

            case (state)
                ST_DONE_D: begin
                    DATA_OUT   <= acc;
                    DATA_VALID <= 1'b1;
                end
                ST_DONE_R: STATE_R_REQ <= 1'b1;
                ST_DONE_F: FAIL_OUT    <= 1'b1;
                default: ;
            endcase

            if (timeout_hit) begin
                FAIL_OUT <= 1'b1;
                state    <= ST_IDLE;
                acc      <= '0;
                cnt      <= '0;
                to_cnt   <= '0;
            end else begin
                if (RX_VALID || !in_line) begin
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end

                if (RX_VALID) begin
                    case (cur_state)
                        ST_IDLE: begin
                            if (rx_term) begin
                                state <= ST_IDLE;
                            end else if (is_hex) begin
                                state <= ST_HEX;
                                acc   <= {28'h0, nib};
                                cnt   <= CNT_W'(1);
                            end else if (rx_rcmd) begin
                                state <= ST_CMD_R;
                            end else begin
                                state <= ST_ERR;
                            end
                        end
                        ST_HEX: begin
                            if (is_hex) begin
                                if (cnt == CNT_MAX) begin
                                    state <= ST_ERR;
                                end else begin
                                    acc <= {acc[27:0], nib};
                                    cnt <= cnt + CNT_W'(1);
                                end
                            end else if (rx_term) begin
                                state <= ST_DONE_D;
                            end else begin
                                state <= ST_ERR;
                            end
                        end
                        ST_CMD_R: begin
                            state <= rx_term ? ST_DONE_R : ST_ERR;
                        end
                        ST_ERR: begin
                            if (rx_term) begin
                                state <= ST_DONE_F;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end else if (is_done) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

endmodule
